// File: rtl/v_pkg.sv
// ----------------------------------------------------------------------------
// v_pkg
// Shared types and constants for the v_* table pipeline. The table is
// ENTRIES_N entries of {valid, key, volume}. This package also holds the
// read-side query types used by v_pipe_query:
//   query_cmd_t  - query opcode (LOOKUP / LIST); other encodings are illegal
//   QRY_IDX_W    - width of an entry index
//   query_rsp_t  - one response beat {hit, err, last, idx, key, volume}
// ----------------------------------------------------------------------------
package v_pkg;

   localparam int ENTRIES_N = 16;

   typedef logic [31:0] key_t;
   typedef logic [31:0] volume_t;

   localparam int KEY_W     = $bits(key_t);
   localparam int VOLUME_W  = $bits(volume_t);
   localparam int QRY_IDX_W = $clog2(ENTRIES_N);

   typedef enum logic [1:0] {
      QRY_LOOKUP = 2'b01,
      QRY_LIST   = 2'b10
   } query_cmd_t;

   typedef struct packed {
      logic                 hit;
      logic                 err;
      logic                 last;
      logic [QRY_IDX_W-1:0] idx;
      key_t                 key;
      volume_t              volume;
   } query_rsp_t;

endpackage

// File: rtl/v_cmp.sv
// ----------------------------------------------------------------------------
// v_cmp
// Key comparator shared by the table pipelines. Only the equality result is
// needed by its users.
// Ports:
//   i_a, i_b  keys to compare
//   o_eq      1 when the keys are identical
// ----------------------------------------------------------------------------
module v_cmp
   import v_pkg::*;
(
   input  key_t i_a,
   input  key_t i_b,
   output logic o_eq
);

   assign o_eq = (i_a == i_b);

endmodule

// File: rtl/v_pipe_query_pri.sv
// ----------------------------------------------------------------------------
// v_pipe_query_pri
// Priority encoder: finds the lowest set bit of i_vec whose position is at or
// above i_start.
// Ports:
//   i_vec    request vector
//   i_start  lowest position that may be selected
//   o_idx    index of the selected bit (0 when nothing is found)
//   o_found  1 when some bit at or above i_start is set
// ----------------------------------------------------------------------------
module v_pipe_query_pri #(
   parameter int N     = 16,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_vec,
   input  logic [IDX_W-1:0] i_start,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_found
);

   // Scanning downwards lets the lowest qualifying bit overwrite any higher one.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i] && (i >= int'(i_start))) begin
            o_idx   = IDX_W'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/v_pipe_query.sv
// ----------------------------------------------------------------------------
// v_pipe_query
// Read-side query engine for the table. A query is accepted on a valid/ready
// handshake and answered from the table state at the accept cycle:
//   LOOKUP - one beat with the lowest-index entry whose key matches
//   LIST   - one beat per valid entry, ascending index, from a snapshot
//   other  - one error beat
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   i_qry_vld/i_qry_cmd/i_qry_key, o_qry_rdy   query handshake
//   i_stcur_vld_r/keys_r/volumes_r             current table state (flat buses)
//   o_rsp_vld, i_rsp_rdy        response beat handshake
//   o_rsp_hit/err/last/idx/key/volume          response beat payload
// ----------------------------------------------------------------------------
module v_pipe_query
   import v_pkg::*;
(
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic                          i_qry_vld,
   input  logic [1:0]                    i_qry_cmd,
   input  logic [KEY_W-1:0]              i_qry_key,
   output logic                          o_qry_rdy,
   input  logic [ENTRIES_N-1:0]          i_stcur_vld_r,
   input  logic [ENTRIES_N*KEY_W-1:0]    i_stcur_keys_r,
   input  logic [ENTRIES_N*VOLUME_W-1:0] i_stcur_volumes_r,
   output logic                          o_rsp_vld,
   input  logic                          i_rsp_rdy,
   output logic                          o_rsp_hit,
   output logic                          o_rsp_err,
   output logic                          o_rsp_last,
   output logic [QRY_IDX_W-1:0]          o_rsp_idx,
   output logic [KEY_W-1:0]              o_rsp_key,
   output logic [VOLUME_W-1:0]           o_rsp_volume
);

   localparam int IDX_W = QRY_IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RSP,
      ST_LIST
   } state_t;

   state_t                   state_q, state_d;
   logic                     qry_rdy_q, qry_rdy_d;
   logic                     rsp_vld_q, rsp_vld_d;
   query_rsp_t               rsp_q, rsp_d;
   logic [ENTRIES_N-1:0]     snap_vld_q, snap_vld_d;
   key_t    [ENTRIES_N-1:0]  snap_keys_q, snap_keys_d;
   volume_t [ENTRIES_N-1:0]  snap_vols_q, snap_vols_d;

   key_t    [ENTRIES_N-1:0]  cur_keys;
   volume_t [ENTRIES_N-1:0]  cur_vols;
   logic [ENTRIES_N-1:0]     key_eq;
   logic [ENTRIES_N-1:0]     match_vec;

   logic                     in_list;
   logic                     accept;
   logic [ENTRIES_N-1:0]     vld_src;
   logic [ENTRIES_N-1:0]     vec_a, vec_b;
   logic [IDX_W-1:0]         start_a;
   logic [IDX_W-1:0]         a_idx, b_idx, c_idx;
   logic                     a_found, b_found, c_found;

   assign cur_keys  = i_stcur_keys_r;
   assign cur_vols  = i_stcur_volumes_r;
   assign in_list   = (state_q == ST_LIST);
   assign accept    = i_qry_vld & qry_rdy_q;

   for (genvar g = 0; g < ENTRIES_N; g++) begin : g_cmp
      v_cmp u_cmp (
         .i_a  (cur_keys[g]),
         .i_b  (i_qry_key),
         .o_eq (key_eq[g])
      );
   end

   assign match_vec = key_eq & i_stcur_vld_r;

   // Encoder A picks the entry for the beat being prepared: the first valid
   // entry when a LIST is accepted, or the next valid entry above the current
   // beat while listing. Encoder B looks past A's pick to decide whether that
   // beat is the final one. The current beat's own bit is masked so that
   // "at or above" behaves as "strictly above" without index arithmetic.
   always_comb begin
      vld_src = in_list ? snap_vld_q : i_stcur_vld_r;
      start_a = in_list ? rsp_q.idx : '0;
      vec_a   = '0;
      vec_b   = '0;
      for (int i = 0; i < ENTRIES_N; i++) begin
         vec_a[i] = vld_src[i] && !(in_list && (IDX_W'(i) == rsp_q.idx));
         vec_b[i] = vld_src[i] && (IDX_W'(i) != a_idx);
      end
   end

   v_pipe_query_pri #(.N(ENTRIES_N), .IDX_W(IDX_W)) u_pri_next (
      .i_vec   (vec_a),
      .i_start (start_a),
      .o_idx   (a_idx),
      .o_found (a_found)
   );

   v_pipe_query_pri #(.N(ENTRIES_N), .IDX_W(IDX_W)) u_pri_last (
      .i_vec   (vec_b),
      .i_start (a_idx),
      .o_idx   (b_idx),
      .o_found (b_found)
   );

   v_pipe_query_pri #(.N(ENTRIES_N), .IDX_W(IDX_W)) u_pri_match (
      .i_vec   (match_vec),
      .i_start ('0),
      .o_idx   (c_idx),
      .o_found (c_found)
   );

   // Next-state logic. The first beat of every query is built from the live
   // buses in the accept cycle, which hold exactly the values being captured
   // into the snapshot, so the beat appears one cycle after accept. Later LIST
   // beats come from the snapshot only. Everything holds while a beat stalls.
   always_comb begin
      state_d     = state_q;
      rsp_vld_d   = rsp_vld_q;
      rsp_d       = rsp_q;
      snap_vld_d  = snap_vld_q;
      snap_keys_d = snap_keys_q;
      snap_vols_d = snap_vols_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               snap_vld_d  = i_stcur_vld_r;
               snap_keys_d = cur_keys;
               snap_vols_d = cur_vols;
               rsp_vld_d   = 1'b1;
               rsp_d       = '0;
               rsp_d.last  = 1'b1;
               case (i_qry_cmd)
                  QRY_LOOKUP: begin
                     state_d   = ST_RSP;
                     rsp_d.key = i_qry_key;
                     if (c_found) begin
                        rsp_d.hit    = 1'b1;
                        rsp_d.idx    = c_idx;
                        rsp_d.key    = cur_keys[c_idx];
                        rsp_d.volume = cur_vols[c_idx];
                     end
                  end
                  QRY_LIST: begin
                     state_d = ST_LIST;
                     if (a_found) begin
                        rsp_d.hit    = 1'b1;
                        rsp_d.idx    = a_idx;
                        rsp_d.key    = cur_keys[a_idx];
                        rsp_d.volume = cur_vols[a_idx];
                        rsp_d.last   = !b_found;
                     end
                  end
                  default: begin
                     state_d   = ST_RSP;
                     rsp_d.err = 1'b1;
                  end
               endcase
            end
         end
         ST_RSP: begin
            if (i_rsp_rdy) begin
               state_d   = ST_IDLE;
               rsp_vld_d = 1'b0;
               rsp_d     = '0;
            end
         end
         ST_LIST: begin
            if (i_rsp_rdy) begin
               if (rsp_q.last) begin
                  state_d   = ST_IDLE;
                  rsp_vld_d = 1'b0;
                  rsp_d     = '0;
               end else begin
                  rsp_d        = '0;
                  rsp_d.hit    = 1'b1;
                  rsp_d.idx    = a_idx;
                  rsp_d.key    = snap_keys_q[a_idx];
                  rsp_d.volume = snap_vols_q[a_idx];
                  rsp_d.last   = !b_found;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rsp_vld_d = 1'b0;
            rsp_d     = '0;
         end
      endcase

      qry_rdy_d = (state_d == ST_IDLE);
   end

   // State and output registers. Ready resets low and rises on the first
   // clock after reset release, so it is never high while reset is asserted.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= ST_IDLE;
         qry_rdy_q   <= 1'b0;
         rsp_vld_q   <= 1'b0;
         rsp_q       <= '0;
         snap_vld_q  <= '0;
         snap_keys_q <= '0;
         snap_vols_q <= '0;
      end else begin
         state_q     <= state_d;
         qry_rdy_q   <= qry_rdy_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_q       <= rsp_d;
         snap_vld_q  <= snap_vld_d;
         snap_keys_q <= snap_keys_d;
         snap_vols_q <= snap_vols_d;
      end
   end

   assign o_qry_rdy    = qry_rdy_q;
   assign o_rsp_vld    = rsp_vld_q;
   assign o_rsp_hit    = rsp_q.hit;
   assign o_rsp_err    = rsp_q.err;
   assign o_rsp_last   = rsp_q.last;
   assign o_rsp_idx    = rsp_q.idx;
   assign o_rsp_key    = rsp_q.key;
   assign o_rsp_volume = rsp_q.volume;

endmodule

// File: tb/tb_v_pipe_query.sv
// ----------------------------------------------------------------------------
// tb_v_pipe_query
// Bench for v_pipe_query. A behavioural model turns each accepted query into
// the list of beats it must produce, using the table contents at the accept
// cycle; a compare process checks every cycle against that list. Directed
// literal expectations pin the model on the interesting cases.
// ----------------------------------------------------------------------------
module tb_v_pipe_query;
   import v_pkg::*;

   logic                          clk = 1'b0;
   logic                          arst_n = 1'b0;
   logic                          i_qry_vld = 1'b0;
   logic [1:0]                    i_qry_cmd = 2'b00;
   logic [KEY_W-1:0]              i_qry_key = '0;
   logic                          o_qry_rdy;
   logic [ENTRIES_N-1:0]          stVld;
   logic [ENTRIES_N*KEY_W-1:0]    stKeys;
   logic [ENTRIES_N*VOLUME_W-1:0] stVols;
   logic                          o_rsp_vld;
   logic                          i_rsp_rdy = 1'b1;
   logic                          o_rsp_hit, o_rsp_err, o_rsp_last;
   logic [QRY_IDX_W-1:0]          o_rsp_idx;
   logic [KEY_W-1:0]              o_rsp_key;
   logic [VOLUME_W-1:0]           o_rsp_volume;

   logic [ENTRIES_N-1:0] tbVld = '0;
   logic [31:0]          tbKeys [ENTRIES_N];
   logic [31:0]          tbVols [ENTRIES_N];

   typedef struct {
      logic        hit;
      logic        err;
      logic        last;
      logic [3:0]  idx;
      logic [31:0] key;
      logic [31:0] vol;
   } beat_t;

   beat_t expQ [$];
   beat_t expB;
   int    nChecks = 0;
   int    nPass   = 0;
   int    sinceRst = 0;

   v_pipe_query dut (
      .clk               (clk),
      .arst_n            (arst_n),
      .i_qry_vld         (i_qry_vld),
      .i_qry_cmd         (i_qry_cmd),
      .i_qry_key         (i_qry_key),
      .o_qry_rdy         (o_qry_rdy),
      .i_stcur_vld_r     (stVld),
      .i_stcur_keys_r    (stKeys),
      .i_stcur_volumes_r (stVols),
      .o_rsp_vld         (o_rsp_vld),
      .i_rsp_rdy         (i_rsp_rdy),
      .o_rsp_hit         (o_rsp_hit),
      .o_rsp_err         (o_rsp_err),
      .o_rsp_last        (o_rsp_last),
      .o_rsp_idx         (o_rsp_idx),
      .o_rsp_key         (o_rsp_key),
      .o_rsp_volume      (o_rsp_volume)
   );

   always #5 clk = ~clk;

   // Flatten the bench's table arrays onto the DUT state buses.
   always_comb begin
      stVld  = tbVld;
      stKeys = '0;
      stVols = '0;
      for (int i = 0; i < ENTRIES_N; i++) begin
         stKeys[i*KEY_W +: KEY_W]       = tbKeys[i];
         stVols[i*VOLUME_W +: VOLUME_W] = tbVols[i];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
      else nPass++;
   endtask

   // Model: the beats a query must produce, given the table right now.
   function automatic void modelQuery(input logic [1:0] cmd, input logic [31:0] key);
      beat_t b;
      bit    found;
      int    lastIdx;
      b       = '{default: '0};
      found   = 1'b0;
      lastIdx = -1;
      if (cmd == 2'b01) begin
         b.last = 1'b1;
         b.key  = key;
         for (int i = 0; i < ENTRIES_N; i++) begin
            if (!found && tbVld[i] && tbKeys[i] == key) begin
               found = 1'b1;
               b.hit = 1'b1;
               b.idx = 4'(i);
               b.vol = tbVols[i];
            end
         end
         expQ.push_back(b);
      end else if (cmd == 2'b10) begin
         for (int i = 0; i < ENTRIES_N; i++) if (tbVld[i]) lastIdx = i;
         if (lastIdx < 0) begin
            b.last = 1'b1;
            expQ.push_back(b);
         end else begin
            for (int i = 0; i < ENTRIES_N; i++) begin
               if (tbVld[i]) begin
                  b.hit  = 1'b1;
                  b.idx  = 4'(i);
                  b.key  = tbKeys[i];
                  b.vol  = tbVols[i];
                  b.last = (i == lastIdx);
                  expQ.push_back(b);
               end
            end
         end
      end else begin
         b.err  = 1'b1;
         b.last = 1'b1;
         expQ.push_back(b);
      end
   endfunction

   // Per-cycle comparison on the falling edge, where inputs and outputs are
   // both settled for the coming rising edge. Any beat with nothing expected,
   // or a missing beat while something is owed, is a failure.
   always @(negedge clk) begin
      if (!arst_n) begin
         expQ.delete();
         sinceRst = 0;
         checkOutput("rst_rsp_vld", 64'(o_rsp_vld), 64'd0);
         checkOutput("rst_qry_rdy", 64'(o_qry_rdy), 64'd0);
      end else begin
         if (sinceRst < 10) sinceRst++;
         if (sinceRst >= 2) checkOutput("qry_rdy", 64'(o_qry_rdy), 64'(expQ.size() == 0));
         if (expQ.size() != 0) begin
            checkOutput("rsp_vld", 64'(o_rsp_vld), 64'd1);
            if (o_rsp_vld) begin
               expB = expQ[0];
               checkOutput("rsp_hit",  64'(o_rsp_hit),  64'(expB.hit));
               checkOutput("rsp_err",  64'(o_rsp_err),  64'(expB.err));
               checkOutput("rsp_last", 64'(o_rsp_last), 64'(expB.last));
               checkOutput("rsp_idx",  64'(o_rsp_idx),  64'(expB.idx));
               checkOutput("rsp_key",  64'(o_rsp_key),  64'(expB.key));
               checkOutput("rsp_vol",  64'(o_rsp_volume), 64'(expB.vol));
               if (i_rsp_rdy) void'(expQ.pop_front());
            end
         end else begin
            checkOutput("no_beat", 64'(o_rsp_vld), 64'd0);
         end
         if (i_qry_vld && o_qry_rdy) modelQuery(i_qry_cmd, i_qry_key);
      end
   end

   task automatic clearTable();
      tbVld = '0;
      for (int i = 0; i < ENTRIES_N; i++) begin
         tbKeys[i] = 32'h0;
         tbVols[i] = 32'h0;
      end
   endtask

   task automatic setEntry(input int i, input logic [31:0] k, input logic [31:0] v);
      tbVld[i]  = 1'b1;
      tbKeys[i] = k;
      tbVols[i] = v;
   endtask

   // Present one query and return just after the edge that accepted it.
   task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] key);
      int waited;
      waited    = 0;
      i_qry_vld = 1'b1;
      i_qry_cmd = cmd;
      i_qry_key = key;
      @(negedge clk);
      while (!o_qry_rdy && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("qry_accept", 64'(o_qry_rdy), 64'd1);
      @(posedge clk);
      #1;
      i_qry_vld = 1'b0;
      i_qry_cmd = 2'b00;
      i_qry_key = '0;
   endtask

   task automatic waitIdle();
      int waited;
      waited = 0;
      @(negedge clk);
      while (!(o_qry_rdy && expQ.size() == 0) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("idle_reached", 64'(o_qry_rdy && expQ.size() == 0), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clearTable();
      repeat (3) @(negedge clk);
      checkOutput("rst_idx", 64'(o_rsp_idx), 64'd0);
      checkOutput("rst_key", 64'(o_rsp_key), 64'd0);
      checkOutput("rst_vol", 64'(o_rsp_volume), 64'd0);
      checkOutput("rst_last", 64'(o_rsp_last), 64'd0);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of an 8-entry LIST after three transfers.
      for (int i = 0; i < 8; i++) setEntry(i * 2 + (i > 3 ? 1 : 0), 32'h100 + i, 32'(i * 3 + 1));
      i_rsp_rdy = 1'b1;
      applyStimulus(2'b10, '0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      arst_n = 1'b0;
      #1;
      checkOutput("midrst_vld", 64'(o_rsp_vld), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      arst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("midrst_rdy", 64'(o_qry_rdy), 64'd1);
      @(posedge clk);
      #1;

      // LOOKUP hit on the two-entry table.
      clearTable();
      setEntry(2, 32'h10, 32'd5);
      setEntry(9, 32'h40, 32'd7);
      applyStimulus(2'b01, 32'h40);
      @(negedge clk);
      checkOutput("lk_vld", 64'(o_rsp_vld), 64'd1);
      checkOutput("lk_hit", 64'(o_rsp_hit), 64'd1);
      checkOutput("lk_idx", 64'(o_rsp_idx), 64'd9);
      checkOutput("lk_vol", 64'(o_rsp_volume), 64'd7);
      checkOutput("lk_last", 64'(o_rsp_last), 64'd1);
      @(negedge clk);
      checkOutput("lk_rdy_acc2", 64'(o_qry_rdy), 64'd1);
      @(posedge clk);
      #1;

      // LOOKUP miss.
      applyStimulus(2'b01, 32'h20);
      @(negedge clk);
      checkOutput("miss_hit", 64'(o_rsp_hit), 64'd0);
      checkOutput("miss_key", 64'(o_rsp_key), 64'h20);
      checkOutput("miss_vol", 64'(o_rsp_volume), 64'd0);
      waitIdle();

      // LIST with ready pattern 1,0,0,1.
      applyStimulus(2'b10, '0);
      @(negedge clk);
      checkOutput("list_b0_idx", 64'(o_rsp_idx), 64'd2);
      @(posedge clk);
      #1;
      i_rsp_rdy = 1'b0;
      @(negedge clk);
      checkOutput("list_b1_idx", 64'(o_rsp_idx), 64'd9);
      checkOutput("list_b1_last", 64'(o_rsp_last), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("list_stall_vol", 64'(o_rsp_volume), 64'd7);
      @(posedge clk);
      #1;
      i_rsp_rdy = 1'b1;
      waitIdle();

      // Table update after a LIST is accepted must not be visible.
      i_rsp_rdy = 1'b0;
      applyStimulus(2'b10, '0);
      tbVols[2] = 32'd99;
      @(negedge clk);
      checkOutput("snap_vol", 64'(o_rsp_volume), 64'd5);
      @(posedge clk);
      #1;
      i_rsp_rdy = 1'b1;
      waitIdle();

      // Illegal command.
      applyStimulus(2'b11, 32'h40);
      @(negedge clk);
      checkOutput("ill_err", 64'(o_rsp_err), 64'd1);
      checkOutput("ill_hit", 64'(o_rsp_hit), 64'd0);
      waitIdle();

      // Empty-table LIST.
      clearTable();
      applyStimulus(2'b10, '0);
      @(negedge clk);
      checkOutput("empty_hit", 64'(o_rsp_hit), 64'd0);
      checkOutput("empty_last", 64'(o_rsp_last), 64'd1);
      waitIdle();

      // Duplicate keys: lowest index wins.
      setEntry(6, 32'h10, 32'd8);
      setEntry(4, 32'h10, 32'd3);
      applyStimulus(2'b01, 32'h10);
      @(negedge clk);
      checkOutput("dup_idx", 64'(o_rsp_idx), 64'd4);
      checkOutput("dup_vol", 64'(o_rsp_volume), 64'd3);
      waitIdle();

      // Boundary entries 0 and 15, then a full table with random back-pressure.
      clearTable();
      setEntry(0, 32'hAAAA0000, 32'd11);
      setEntry(15, 32'hBBBB000F, 32'd22);
      applyStimulus(2'b10, '0);
      waitIdle();
      applyStimulus(2'b01, 32'hBBBB000F);
      @(negedge clk);
      checkOutput("top_idx", 64'(o_rsp_idx), 64'd15);
      waitIdle();
      for (int i = 0; i < ENTRIES_N; i++) setEntry(i, 32'h5000 + i, 32'(i * 7));
      applyStimulus(2'b10, '0);
      for (int c = 0; c < 60; c++) begin
         i_rsp_rdy = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      i_rsp_rdy = 1'b1;
      waitIdle();
      applyStimulus(2'b01, 32'h5000);
      applyStimulus(2'b01, 32'h500F);
      waitIdle();

      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
